// File: rtl/reg_dump.sv
// Streams NUM_REGS 32-bit register-file words as little-endian bytes over a valid/ready port.
// Define REG_DUMP_CHECKSUM_EN to append an 8-bit XOR checksum byte after the last register.
module reg_dump #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_addr;
    logic [31:0] r_shift;
    logic [1:0]  r_idx;
    logic        w_xfer;
    logic        w_last_byte;
    logic        w_last_reg;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_xfer      = tx_valid && tx_ready;
    assign w_last_byte = (r_idx == 2'd3);
    assign w_last_reg  = (r_addr == LAST_ADDR);
    assign rd_addr     = r_addr;

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        tx_data  = r_shift[7:0];
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = LOAD;
            end
            LOAD: w_next = SEND;
            SEND: begin
                tx_valid = 1'b1;
                if (w_xfer && w_last_byte) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    w_next = w_last_reg ? CHK : LOAD;
`else
                    w_next = w_last_reg ? DONE : LOAD;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CHK: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
                if (w_xfer) w_next = DONE;
            end
`endif
            DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 5'd0;
            r_shift <= 32'd0;
            r_idx   <= 2'd0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum  <= 8'd0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr <= 5'd0;
                        r_idx  <= 2'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_csum <= 8'd0;
`endif
                    end
                end
                LOAD: begin
                    r_shift <= rd_data;
                    r_idx   <= 2'd0;
                end
                SEND: begin
                    if (w_xfer) begin
                        // Shift right so the next little-endian byte lands in bits 7:0.
                        r_shift <= {8'h00, r_shift[31:8]};
                        r_idx   <= r_idx + 2'd1;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_csum  <= r_csum ^ r_shift[7:0];
`endif
                        if (w_last_byte && !w_last_reg) r_addr <= r_addr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: three instances (NUM_REGS = 32, 2, 1) share one expected-byte queue.
// Only one instance dumps at a time, so a single monitor pops for whichever instance transfers.
`timescale 1ns/1ps
module tb_reg_dump;

    localparam int NI = 3;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start    [NI];
    logic [4:0]  rd_addr  [NI];
    logic [31:0] rd_data  [NI];
    logic [7:0]  tx_data  [NI];
    logic        tx_valid [NI];
    logic        tx_ready [NI];
    logic        busy     [NI];
    logic        done     [NI];
    logic [31:0] regfile  [NI][32];

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            reg_dump #(.NUM_REGS(k == 0 ? 32 : (k == 1 ? 2 : 1))) u_dut (
                .clk      (clk),
                .rst      (rst),
                .start    (start[k]),
                .rd_addr  (rd_addr[k]),
                .rd_data  (rd_data[k]),
                .tx_data  (tx_data[k]),
                .tx_valid (tx_valid[k]),
                .tx_ready (tx_ready[k]),
                .busy     (busy[k]),
                .done     (done[k])
            );
            assign rd_data[k] = regfile[k][rd_addr[k]];
        end
    endgenerate

    function automatic int nregs(int k);
        return (k == 0) ? 32 : ((k == 1) ? 2 : 1);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int xfer_cnt [NI];
    int done_cnt [NI];

    // Monitor: transfers are decided at the next posedge, so valid/ready are stable here.
    initial begin
        for (int k = 0; k < NI; k++) begin
            xfer_cnt[k] = 0;
            done_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NI; k++) begin
                    if (done[k]) done_cnt[k]++;
                    if (busy[k])
                        check($sformatf("rd_addr range inst%0d", k),
                              32'(rd_addr[k] <= 5'(nregs(k) - 1)), 32'd1);
                    if (tx_valid[k] && tx_ready[k]) begin
                        xfer_cnt[k]++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected byte inst%0d: got 0x%0h, expected none", k, tx_data[k]);
                        end else begin
                            check($sformatf("byte inst%0d #%0d", k, xfer_cnt[k]), 32'(tx_data[k]), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue start on instance k and wait for done; latency counts the start cycle and done cycle inclusively.
    task automatic run_dump(int k, int exp_cyc, int exp_bytes, string name);
        int cyc;
        int base_x;
        int base_d;
        bit got;
        base_x = xfer_cnt[k];
        base_d = done_cnt[k];
        got = 0;
        cyc = 0;
        @(posedge clk); #1;
        start[k] = 1'b1;
        while (cyc < 2000 && !got) begin
            @(negedge clk);
            cyc++;
            if (done[k]) got = 1;
            else if (cyc == 1) begin
                @(posedge clk); #1;
                start[k] = 1'b0;
            end
        end
        check({name, " done seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(exp_cyc));
        repeat (3) @(negedge clk);
        check({name, " byte count"}, 32'(xfer_cnt[k] - base_x), 32'(exp_bytes));
        check({name, " done pulses"}, 32'(done_cnt[k] - base_d), 32'd1);
        check({name, " queue drained"}, 32'(exp_q.size()), 32'd0);
        check({name, " idle after"}, 32'(busy[k]), 32'd0);
    endtask

    // Hand patterns: xN = 0x01020300+N streams N,03,02,01; XOR of 0..31 and of 03^02^01 are both zero.
    task automatic push_pat32();
        for (int r = 0; r < 32; r++) begin
            exp_q.push_back(8'(r));
            exp_q.push_back(8'h03);
            exp_q.push_back(8'h02);
            exp_q.push_back(8'h01);
        end
        if (CSUM == 1) exp_q.push_back(8'h00);
    endtask

    initial begin
        int n;
        bit found;
        int base_d;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start[k]    = 1'b0;
            tx_ready[k] = 1'b1;
            for (int r = 0; r < 32; r++) regfile[k][r] = 32'd0;
        end
        for (int r = 0; r < 32; r++) regfile[0][r] = 32'h0102_0300 + 32'(r);
        regfile[1][1] = 32'hDEAD_BEEF;

        // Reset state, observed while rst is still high.
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset rd_addr inst%0d", k), 32'(rd_addr[k]), 32'd0);
            check($sformatf("reset tx_data inst%0d", k), 32'(tx_data[k]), 32'd0);
            check($sformatf("reset tx_valid inst%0d", k), 32'(tx_valid[k]), 32'd0);
            check($sformatf("reset busy inst%0d", k), 32'(busy[k]), 32'd0);
            check($sformatf("reset done inst%0d", k), 32'(done[k]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full 32-register dump with tx_ready held high.
        push_pat32();
        run_dump(0, 5 * 32 + 2 + CSUM, 128 + CSUM, "full32");

        // Backpressure on byte 2 of x7 for 5 cycles.
        push_pat32();
        fork
            run_dump(0, 5 * 32 + 2 + CSUM + 5, 128 + CSUM, "backpressure");
            begin
                n = 0;
                found = 0;
                while (n < 2000 && !found) begin
                    @(posedge clk); #1;
                    n++;
                    if (tx_valid[0] && rd_addr[0] == 5'd7 && tx_data[0] == 8'h02) found = 1;
                end
                check("bp trigger reached", 32'(found), 32'd1);
                tx_ready[0] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp tx_data held", 32'(tx_data[0]), 32'h02);
                    check("bp tx_valid held", 32'(tx_valid[0]), 32'd1);
                end
                @(posedge clk); #1;
                tx_ready[0] = 1'b1;
            end
        join

        // Start pulsed during x10 SEND and again during DONE: both ignored.
        push_pat32();
        fork
            run_dump(0, 5 * 32 + 2 + CSUM, 128 + CSUM, "start_while_busy");
            begin
                n = 0;
                found = 0;
                while (n < 2000 && !found) begin
                    @(posedge clk); #1;
                    n++;
                    if (tx_valid[0] && rd_addr[0] == 5'd10) found = 1;
                end
                check("busy start trigger reached", 32'(found), 32'd1);
                start[0] = 1'b1;
                @(posedge clk); #1;
                start[0] = 1'b0;
                n = 0;
                found = 0;
                while (n < 2000 && !found) begin
                    @(posedge clk); #1;
                    n++;
                    if (done[0]) found = 1;
                end
                check("done start trigger reached", 32'(found), 32'd1);
                start[0] = 1'b1;
                @(posedge clk); #1;
                start[0] = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("no dump after DONE start", 32'(busy[0]), 32'd0);

        // Reset mid-SEND aborts at once and never produces done.
        push_pat32();
        base_d = done_cnt[0];
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        found = 0;
        while (n < 2000 && !found) begin
            @(posedge clk); #1;
            n++;
            if (tx_valid[0] && rd_addr[0] == 5'd3) found = 1;
        end
        check("reset trigger reached", 32'(found), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort tx_valid", 32'(tx_valid[0]), 32'd0);
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort rd_addr", 32'(rd_addr[0]), 32'd0);
        check("abort tx_data", 32'(tx_data[0]), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort no done", 32'(done_cnt[0] - base_d), 32'd0);
        check("abort stays idle", 32'(busy[0]), 32'd0);

        // NUM_REGS=2: x0=0, x1=0xDEADBEEF; checksum 0xDE^0xAD^0xBE^0xEF = 0x22.
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hDE);
        if (CSUM == 1) exp_q.push_back(8'h22);
        run_dump(1, 5 * 2 + 2 + CSUM, 8 + CSUM, "nregs2");

        // NUM_REGS=1 corner: four zero bytes, rd_addr pinned at 0.
        for (int b = 0; b < 4 + CSUM; b++) exp_q.push_back(8'h00);
        run_dump(2, 5 * 1 + 2 + CSUM, 4 + CSUM, "nregs1");
        check("nregs1 rd_addr", 32'(rd_addr[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
